// File: rtl/bp_me_bedrock_burst_monitor.sv
// bp_me_bedrock_burst_monitor
// Passive multi-channel BedRock burst checker. Each channel follows header and
// data handshakes, tracks outstanding beats, counts traffic and flags orphan
// beats, overlapping headers and long handshake stalls.
module bp_me_bedrock_burst_monitor #(
  parameter int num_channels_p  = 4,
  parameter int data_width_p    = 64,
  parameter int counter_width_p = 32,
  parameter int stall_limit_p   = 1024,
  localparam int SelW = (num_channels_p > 1) ? $clog2(num_channels_p) : 1
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic                         clear_i,
  input  logic [num_channels_p-1:0]    hdr_v_i,
  input  logic [num_channels_p-1:0]    hdr_ready_and_i,
  input  logic [num_channels_p-1:0]    hdr_has_data_i,
  input  logic [3*num_channels_p-1:0]  hdr_size_i,
  input  logic [num_channels_p-1:0]    data_v_i,
  input  logic [num_channels_p-1:0]    data_ready_and_i,
  input  logic [SelW-1:0]              sel_i,
  output logic [counter_width_p-1:0]   hdr_count_o,
  output logic [counter_width_p-1:0]   beat_count_o,
  output logic [num_channels_p-1:0]    busy_o,
  output logic [num_channels_p-1:0]    err_o,
  output logic [2*num_channels_p-1:0]  err_code_o
);

  localparam int LgBytesPerBeat = $clog2(data_width_p / 8);
  localparam int StallW = $clog2(stall_limit_p + 1);
  localparam logic [StallW-1:0] StallLimit = StallW'(stall_limit_p);
  localparam int NumSlots = 1 << SelW;

  typedef enum logic {IDLE, DATA} state_e;

  // Counter views padded to a power of two so out-of-range selects read zero
  logic [counter_width_p-1:0] hdrCnt  [NumSlots];
  logic [counter_width_p-1:0] beatCnt [NumSlots];

  // Beats in a message: bytes / bytes-per-beat, never fewer than one
  function automatic logic [7:0] beatsOf(input logic [2:0] size);
    if (int'(size) > LgBytesPerBeat) return 8'd1 << (int'(size) - LgBytesPerBeat);
    else return 8'd1;
  endfunction

  for (genvar c = 0; c < num_channels_p; c++) begin : g_ch
    state_e                     state_q, state_d;
    logic [7:0]                 rem_q, rem_d;
    logic [StallW-1:0]          stall_q, stall_d;
    logic [counter_width_p-1:0] hdrCnt_q, hdrCnt_d, beatCnt_q, beatCnt_d;
    logic                       err_q;
    logic [1:0]                 code_q;
    logic                       hdrFire, beatFire, stallCond;
    logic                       orphan, overlap, stallErr, anyErr;
    logic [7:0]                 msgBeats, remNew, remAfter;

    assign hdrFire   = hdr_v_i[c] & hdr_ready_and_i[c];
    assign beatFire  = data_v_i[c] & data_ready_and_i[c];
    assign stallCond = (hdr_v_i[c] & ~hdr_ready_and_i[c]) |
                       (data_v_i[c] & ~data_ready_and_i[c]);
    assign msgBeats  = hdr_has_data_i[c] ? beatsOf(hdr_size_i[3*c +: 3]) : 8'd0;
    assign remNew    = (msgBeats != 8'd0) ? (msgBeats - {7'd0, beatFire}) : 8'd0;
    assign remAfter  = rem_q - {7'd0, beatFire};

    // Burst FSM next state: a header landing on the final beat starts a fresh
    // message; one landing earlier is an overlap and replaces the old message
    always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      orphan  = 1'b0;
      overlap = 1'b0;
      case (state_q)
        IDLE: begin
          if (hdrFire) begin
            rem_d   = remNew;
            state_d = (remNew != 8'd0) ? DATA : IDLE;
          end else if (beatFire) begin
            orphan = 1'b1;
          end
        end
        DATA: begin
          if (!hdrFire) begin
            rem_d   = remAfter;
            state_d = (remAfter != 8'd0) ? DATA : IDLE;
          end else if (remAfter == 8'd0) begin
            rem_d   = msgBeats;
            state_d = (msgBeats != 8'd0) ? DATA : IDLE;
          end else begin
            overlap = 1'b1;
            rem_d   = remNew;
            state_d = (remNew != 8'd0) ? DATA : IDLE;
          end
        end
        default: begin
          state_d = IDLE;
          rem_d   = 8'd0;
        end
      endcase
    end

    // Stall run length and saturating traffic counters
    always_comb begin
      stall_d   = '0;
      stallErr  = 1'b0;
      if (stallCond) begin
        stall_d  = (stall_q == StallLimit) ? stall_q : stall_q + 1'b1;
        stallErr = (stall_q == StallLimit - 1'b1);
      end
      hdrCnt_d  = (hdrFire && hdrCnt_q != '1) ? hdrCnt_q + 1'b1 : hdrCnt_q;
      beatCnt_d = (beatFire && beatCnt_q != '1) ? beatCnt_q + 1'b1 : beatCnt_q;
      anyErr    = orphan | overlap | stallErr;
    end

    // Channel state register; clear behaves like reset but synchronously
    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        state_q   <= IDLE;
        rem_q     <= '0;
        stall_q   <= '0;
        hdrCnt_q  <= '0;
        beatCnt_q <= '0;
        err_q     <= 1'b0;
        code_q    <= 2'b00;
      end else if (clear_i) begin
        state_q   <= IDLE;
        rem_q     <= '0;
        stall_q   <= '0;
        hdrCnt_q  <= '0;
        beatCnt_q <= '0;
        err_q     <= 1'b0;
        code_q    <= 2'b00;
      end else begin
        state_q   <= state_d;
        rem_q     <= rem_d;
        stall_q   <= stall_d;
        hdrCnt_q  <= hdrCnt_d;
        beatCnt_q <= beatCnt_d;
        err_q     <= err_q | anyErr;
        if (!err_q && anyErr)
          code_q <= orphan ? 2'b01 : (overlap ? 2'b10 : 2'b11);
      end
    end

    assign busy_o[c]             = (state_q == DATA);
    assign err_o[c]              = err_q;
    assign err_code_o[2*c +: 2]  = code_q;
    assign hdrCnt[c]             = hdrCnt_q;
    assign beatCnt[c]            = beatCnt_q;
  end

  for (genvar s = num_channels_p; s < NumSlots; s++) begin : g_pad
    assign hdrCnt[s]  = '0;
    assign beatCnt[s] = '0;
  end

  // Registered readout of the selected channel's counters
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      hdr_count_o  <= '0;
      beat_count_o <= '0;
    end else begin
      hdr_count_o  <= hdrCnt[sel_i];
      beat_count_o <= beatCnt[sel_i];
    end
  end

endmodule

// File: tb/tb_bp_me_bedrock_burst_monitor.sv
// Randomized scoreboard bench for bp_me_bedrock_burst_monitor with three
// channels, 64-bit beats, 4-bit counters and a stall limit of 4.
module tb_bp_me_bedrock_burst_monitor;

  localparam int NCH = 3;
  localparam int DW  = 64;
  localparam int CW  = 4;
  localparam int SL  = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          resetN = 1'b0;
  logic          clear = 1'b0;
  logic [2:0]    hdrV = '0, hdrReady = '0, hdrHasData = '0;
  logic [8:0]    hdrSize = '0;
  logic [2:0]    dataV = '0, dataReady = '0;
  logic [1:0]    sel = '0;
  logic [CW-1:0] hdrCount, beatCount;
  logic [2:0]    busy, err;
  logic [5:0]    errCode;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [2:0]    busy;
    logic [2:0]    err;
    logic [5:0]    code;
    logic [CW-1:0] hc;
    logic [CW-1:0] bc;
    bit            chkCnt;
  } exp_t;

  exp_t sb[$];

  // Reference model: outstanding beats and plain integer counters per channel
  int mOut[NCH], mHdr[NCH], mBeat[NCH], mRun[NCH], mErr[NCH], mCode[NCH];

  bp_me_bedrock_burst_monitor #(
    .num_channels_p(NCH), .data_width_p(DW),
    .counter_width_p(CW), .stall_limit_p(SL)
  ) dut (
    .clk_i(clk), .reset_n_i(resetN), .clear_i(clear),
    .hdr_v_i(hdrV), .hdr_ready_and_i(hdrReady), .hdr_has_data_i(hdrHasData),
    .hdr_size_i(hdrSize), .data_v_i(dataV), .data_ready_and_i(dataReady),
    .sel_i(sel), .hdr_count_o(hdrCount), .beat_count_o(beatCount),
    .busy_o(busy), .err_o(err), .err_code_o(errCode)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL timeout: bench did not finish, got no end, wanted end");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string nm, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  function automatic int beatsFor(input int size);
    int b;
    b = (1 << size) / (DW / 8);
    return (b < 1) ? 1 : b;
  endfunction

  function automatic void modelReset();
    for (int c = 0; c < NCH; c++) begin
      mOut[c] = 0; mHdr[c] = 0; mBeat[c] = 0;
      mRun[c] = 0; mErr[c] = 0; mCode[c] = 0;
    end
  endfunction

  function automatic void modelStep(input logic [2:0] hv, hr, hd, input logic [8:0] sz,
                                    input logic [2:0] dv, dr);
    for (int c = 0; c < NCH; c++) begin
      bit hf, bf, orphan, overlap, stall, cond;
      int msg, left, nxt;
      hf = hv[c] && hr[c];
      bf = dv[c] && dr[c];
      orphan = 0; overlap = 0; stall = 0;
      msg = hd[c] ? beatsFor(int'(sz[3*c +: 3])) : 0;
      if (mOut[c] == 0) begin
        if (hf) nxt = (msg > 0) ? msg - int'(bf) : 0;
        else begin nxt = 0; orphan = bf; end
      end else begin
        left = mOut[c] - int'(bf);
        if (!hf) nxt = left;
        else if (left == 0) nxt = msg;
        else begin overlap = 1; nxt = (msg > 0) ? msg - int'(bf) : 0; end
      end
      mOut[c] = nxt;
      cond = (hv[c] && !hr[c]) || (dv[c] && !dr[c]);
      if (cond) begin
        if (mRun[c] == SL - 1) stall = 1;
        mRun[c] = (mRun[c] + 1 > SL) ? SL : mRun[c] + 1;
      end else mRun[c] = 0;
      if ((orphan || overlap || stall) && mErr[c] == 0) begin
        mErr[c] = 1;
        mCode[c] = orphan ? 1 : (overlap ? 2 : 3);
      end
      if (hf) mHdr[c] = (mHdr[c] >= CMAX) ? CMAX : mHdr[c] + 1;
      if (bf) mBeat[c] = (mBeat[c] >= CMAX) ? CMAX : mBeat[c] + 1;
    end
  endfunction

  // One clock of stimulus: drive inputs, advance model, queue expectation
  task automatic applyStimulus(input logic [2:0] hv, hr, hd, input logic [8:0] sz,
                               input logic [2:0] dv, dr, input logic [1:0] s,
                               input logic clr);
    exp_t e;
    @(negedge clk);
    hdrV = hv; hdrReady = hr; hdrHasData = hd; hdrSize = sz;
    dataV = dv; dataReady = dr; sel = s; clear = clr;
    e.hc = (int'(s) < NCH) ? CW'(mHdr[s]) : '0;
    e.bc = (int'(s) < NCH) ? CW'(mBeat[s]) : '0;
    e.chkCnt = !clr;
    if (clr) modelReset();
    else modelStep(hv, hr, hd, sz, dv, dr);
    for (int c = 0; c < NCH; c++) begin
      e.busy[c] = (mOut[c] > 0);
      e.err[c]  = (mErr[c] != 0);
      e.code[2*c +: 2] = 2'(mCode[c]);
    end
    sb.push_back(e);
  endtask

  task automatic chanCycle(input int ch, input logic hv, hr, hd, input logic [2:0] sz,
                           input logic dv, dr);
    logic [2:0] vh, vr, vd, vdv, vdr;
    logic [8:0] vs;
    vh = '0; vr = '0; vd = '0; vdv = '0; vdr = '0; vs = '0;
    vh[ch] = hv; vr[ch] = hr; vd[ch] = hd; vdv[ch] = dv; vdr[ch] = dr;
    vs[3*ch +: 3] = sz;
    applyStimulus(vh, vr, vd, vs, vdv, vdr, 2'(ch), 1'b0);
  endtask

  task automatic idleCycles(input int n, input int ch);
    repeat (n) applyStimulus('0, '0, '0, '0, '0, '0, 2'(ch), 1'b0);
  endtask

  task automatic clearCycle();
    applyStimulus('0, '0, '0, '0, '0, '0, 2'd0, 1'b1);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " busy"}, busy, 0);
    checkOutput({tag, " err"}, err, 0);
    checkOutput({tag, " err_code"}, errCode, 0);
    checkOutput({tag, " hdr_count"}, hdrCount, 0);
    checkOutput({tag, " beat_count"}, beatCount, 0);
  endtask

  // Monitor: each rising edge retires the oldest queued expectation
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checkOutput("busy", busy, e.busy);
      checkOutput("err", err, e.err);
      checkOutput("err_code", errCode, e.code);
      if (e.chkCnt) begin
        checkOutput("hdr_count", hdrCount, e.hc);
        checkOutput("beat_count", beatCount, e.bc);
      end
    end
  end

  task automatic randomCycles(input int n);
    repeat (n) begin
      logic [2:0] hv, hr, hd, dv, dr;
      logic [8:0] sz;
      logic clr;
      for (int c = 0; c < NCH; c++) begin
        hv[c] = ($urandom % 5) == 0;
        hr[c] = ($urandom % 4) != 0;
        hd[c] = ($urandom % 10) < 7;
        sz[3*c +: 3] = 3'($urandom % 8);
        dv[c] = (mOut[c] > 0) ? (($urandom % 10) < 7) : (($urandom % 25) == 0);
        dr[c] = ($urandom % 4) != 0;
      end
      clr = ($urandom % 150) == 0;
      applyStimulus(hv, hr, hd, sz, dv, dr, 2'($urandom % 4), clr);
    end
  endtask

  initial begin
    modelReset();
    #12;
    checkAllZero("reset");
    @(negedge clk);
    resetN = 1'b1;

    // Size 6 burst on channel 0: eight back-to-back beats
    chanCycle(0, 1, 1, 1, 3'd6, 0, 0);
    repeat (8) chanCycle(0, 0, 0, 0, 3'd0, 1, 1);
    idleCycles(2, 0);

    // Header with first beat, then next header on the final beat
    chanCycle(0, 1, 1, 1, 3'd4, 1, 1);
    chanCycle(0, 1, 1, 1, 3'd4, 1, 1);
    repeat (2) chanCycle(0, 0, 0, 0, 3'd0, 1, 1);
    idleCycles(2, 0);

    // Orphan beat on channel 2, later overlap keeps the orphan code
    chanCycle(2, 0, 0, 0, 3'd0, 1, 1);
    chanCycle(2, 1, 1, 1, 3'd5, 0, 0);
    chanCycle(2, 0, 0, 0, 3'd0, 1, 1);
    chanCycle(2, 1, 1, 1, 3'd5, 0, 0);
    repeat (4) chanCycle(2, 0, 0, 0, 3'd0, 1, 1);
    idleCycles(2, 2);

    // Overlap on channel 1: size 7, three beats, then size 5
    chanCycle(1, 1, 1, 1, 3'd7, 0, 0);
    repeat (3) chanCycle(1, 0, 0, 0, 3'd0, 1, 1);
    chanCycle(1, 1, 1, 1, 3'd5, 0, 0);
    repeat (4) chanCycle(1, 0, 0, 0, 3'd0, 1, 1);
    idleCycles(2, 1);
    clearCycle();

    // Stall: three stalled cycles, a gap, then four
    repeat (3) chanCycle(1, 1, 0, 1, 3'd0, 0, 0);
    idleCycles(1, 1);
    repeat (4) chanCycle(1, 1, 0, 1, 3'd0, 0, 0);
    idleCycles(2, 1);
    clearCycle();

    // Saturation of both counters, then clear in the middle of a burst
    chanCycle(0, 1, 1, 1, 3'd7, 0, 0);
    repeat (16) chanCycle(0, 0, 0, 0, 3'd0, 1, 1);
    repeat (17) chanCycle(0, 1, 1, 0, 3'd0, 0, 0);
    chanCycle(0, 1, 1, 1, 3'd7, 0, 0);
    repeat (5) chanCycle(0, 0, 0, 0, 3'd0, 1, 1);
    idleCycles(2, 0);
    clearCycle();
    idleCycles(3, 0);

    randomCycles(400);

    // Asynchronous reset in the middle of a burst
    chanCycle(0, 1, 1, 1, 3'd7, 0, 0);
    repeat (2) chanCycle(0, 0, 0, 0, 3'd0, 1, 1);
    @(posedge clk);
    #2;
    resetN = 1'b0;
    hdrV = '0; hdrReady = '0; dataV = '0; dataReady = '0; clear = 1'b0;
    modelReset();
    #1;
    checkAllZero("async reset");
    repeat (2) @(negedge clk);
    checkAllZero("reset hold");
    resetN = 1'b1;

    randomCycles(150);
    idleCycles(3, 0);

    @(posedge clk);
    #3;
    checkOutput("scoreboard drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bp_me_bedrock_burst_monitor.md
# bp_me_bedrock_burst_monitor

Synthesizable, multi-channel BedRock burst protocol monitor for CCE/LCE/memory links. It passively observes the header and data handshakes of `num_channels_p` independent ready&valid burst channels. Per channel it tracks the message-to-data-beat relationship, counts headers and beats, and detects protocol violations and handshake stalls. Error and count state is exposed for on-chip debug and for testbench checking, in place of file-based trace output.

## Interface
Parameters:
- `num_channels_p`, default 4: number of monitored burst channels.
- `data_width_p`, default 64: data beat width in bits; power of two, at least 8.
- `counter_width_p`, default 32: width of the header and beat counters.
- `stall_limit_p`, default 1024: number of consecutive stalled cycles that triggers a stall error; must be at least 1.

Ports (clock and reset first):
- `clk_i`, in, 1: the single clock.
- `reset_n_i`, in, 1: reset, asynchronous and active-low.
- `clear_i`, in, 1: synchronous clear of all counters, errors and channel state.
- `hdr_v_i`, in, `num_channels_p`: header valid, one bit per channel.
- `hdr_ready_and_i`, in, `num_channels_p`: header ready.
- `hdr_has_data_i`, in, `num_channels_p`: the header carries data beats.
- `hdr_size_i`, in, 3×`num_channels_p`: BedRock msg size per channel; bytes = 1<<size.
- `data_v_i`, in, `num_channels_p`: data valid.
- `data_ready_and_i`, in, `num_channels_p`: data ready.
- `sel_i`, in, clog2(`num_channels_p`): channel selected for count readout.
- `hdr_count_o`, out, `counter_width_p`: header count of the selected channel.
- `beat_count_o`, out, `counter_width_p`: beat count of the selected channel.
- `busy_o`, out, `num_channels_p`: channel is in the DATA state.
- `err_o`, out, `num_channels_p`: sticky error flag.
- `err_code_o`, out, 2×`num_channels_p`: code of the first error: 01 orphan, 10 overlap, 11 stall, 00 none.

## Operation
- Definitions:
  - A header fire is `hdr_v_i & hdr_ready_and_i`.
  - A beat fire is `data_v_i & data_ready_and_i`.
  - Expected beats = max(1, (1<<size) / (`data_width_p`/8)). For `data_width_p`=64: size 0–3 → 1 beat, 4 → 2, 5 → 4, 6 → 8, 7 → 16.
- Each channel has an independent FSM with states IDLE and DATA, plus a remaining-beat counter `rem`.
- IDLE:
  - Header fire with has_data: consume a beat if one fires in the same cycle.
    - If the remaining beats are greater than 0, go to DATA with `rem` set to the remaining beats.
    - Otherwise stay in IDLE.
  - Header fire without has_data: stay in IDLE.
  - Beat fire with no header fire: orphan error; the beat is still counted.
- DATA:
  - A beat fire decrements `rem`. When `rem` reaches 0, go to IDLE.
  - A header fire in the same cycle as the final beat is legal. The new message starts immediately and is evaluated with the same rules as from IDLE.
  - A header fire while beats remain after this cycle is an overlap error. The new header replaces the old message, and `rem` reloads from the new header, minus any beat fired this cycle.
- Counters:
  - `hdr_count` increments on every header fire.
  - `beat_count` increments on every beat fire.
  - Both saturate at all-ones and never wrap.
- Stall detection:
  - The per-channel stall counter increments in any cycle with (`hdr_v_i` & ~`hdr_ready_and_i`) | (`data_v_i` & ~`data_ready_and_i`).
  - It resets to 0 in any other cycle.
  - When it reaches `stall_limit_p`, a stall error is raised and the counter holds at the limit until the condition clears.
- Errors:
  - `err_o` is sticky.
  - `err_code_o` records only the first error. Later errors set nothing new.
  - Priority when several errors occur in the same cycle: orphan, then overlap, then stall.
- `clear_i`:
  - Zeroes all counters, errors, stall counters and `rem`, and forces every channel to IDLE.
  - Handshakes in the clear cycle are ignored.

## Timing
- Reset: every output is 0 and every channel is IDLE; applies asynchronously on `reset_n_i` low, and state is held while it stays low.
- Reset release: the first handshake is observed on the first rising edge after deassertion.
- `busy_o`, `err_o` and `err_code_o` are registered. They update on the edge that samples the causing handshake, so they are visible 1 cycle later.
- `hdr_count_o` and `beat_count_o` are registered reads of the channel selected by `sel_i`. Latency is 1 cycle from `sel_i` and reflects counter state at that edge.
- A stall error asserts on the edge at which the stall counter becomes `stall_limit_p`, i.e. after `stall_limit_p` consecutive stalled cycles.
- Channels are fully independent. Simultaneous events on different channels never interact.
- `sel_i` values ≥ `num_channels_p` return 0.

## Test plan
- Channel 0, size=6, has_data, back-to-back beats, `data_width_p`=64: 8 beats. → `busy_o`[0] high for 8 cycles; `hdr_count`=1, `beat_count`=8; `err_o`=0.
- Header and first beat in the same cycle (size 4), then a new header together with the final beat. → No error; `busy_o` remains high through the second message; `hdr_count`=2.
- Beat fire on channel 2 in IDLE. → `err_o`[2]=1, `err_code`=01, `beat_count`=1. A later overlap leaves the code at 01.
- Size 7 header, 3 beats, then a new size 5 header. → `err_code`=10; `rem` reloads to 4; 4 further beats return the channel to IDLE.
- `stall_limit_p`=4; `hdr_v` high with ready low for 3 cycles, one gap, then 4 cycles. → Error only after the 4th consecutive cycle, `err_code`=11.
- Drive `counter_width_p`=4 past 15 beats; then pulse `clear_i` mid-DATA; then assert `reset_n_i` low asynchronously mid-burst. → Counts saturate at 15; clear zeroes everything and forces IDLE; async reset zeroes all outputs immediately.
